// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank scheduler: op codes, FSM states and
// the next-state rule of a single JK flip-flop.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_APPLY = 2'b01,
    S_ACK   = 2'b10
  } state_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case (op_e'({j, k}))
      OP_HOLD:   nq = q;
      OP_CLEAR:  nq = 1'b0;
      OP_SET:    nq = 1'b1;
      OP_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_bank_scheduler_if.sv
// Requester-side bus of the JK bank scheduler. The master modport is the
// requester population, the slave modport is the scheduler.
interface jk_bank_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  // Handshake: requester i raises req[i] with op/mask stable and keeps them
  // until it sees gnt[i]; done pulses the cycle after gnt with q already updated.
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  jk_pkg::state_e        dbg_state;

  modport master (
    output req, op, mask,
    input  gnt, done, busy, q, dbg_state
  );

  modport slave (
    input  req, op, mask,
    output gnt, done, busy, q, dbg_state
  );

endinterface

// File: rtl/jk_cell.sv
// Single rising-edge JK flip-flop with asynchronous active-low clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = jk_next(q_q, j, k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that lets NREQ requesters take turns applying a
// masked JK operation to one shared WIDTH-bit bank of jk_cell flops.
module jk_bank_scheduler
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  jk_bank_scheduler_if.slave  bus
);

  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RR_W-1:0]   w_q, w_d;
  logic [1:0]        op_q, op_d;
  logic [WIDTH-1:0]  mask_q, mask_d;

  logic [RR_W-1:0]   pick;
  logic              pick_vld;
  int                idx;

  logic [NREQ-1:0]   gnt_c;
  logic [WIDTH-1:0]  j_c;
  logic [WIDTH-1:0]  k_c;
  logic [WIDTH-1:0]  bank_q;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int n = 1; n <= NREQ; n++) begin
      idx = (int'(rr_ptr_q) + n) % NREQ;
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = RR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    w_d      = w_q;
    op_d     = op_q;
    mask_d   = mask_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          w_d     = pick;
          op_d    = bus.op[2*pick +: 2];
          mask_d  = bus.mask[WIDTH*pick +: WIDTH];
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        rr_ptr_d = w_q;
        state_d  = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // J/K are live only during APPLY, so the bank moves on exactly one edge.
  always_comb begin
    gnt_c = '0;
    j_c   = '0;
    k_c   = '0;
    if (state_q == S_APPLY) begin
      gnt_c[w_q] = 1'b1;
      j_c        = mask_q & {WIDTH{op_q[1]}};
      k_c        = mask_q & {WIDTH{op_q[0]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= RR_W'(NREQ - 1);
      w_q      <= '0;
      op_q     <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      w_q      <= w_d;
      op_q     <= op_d;
      mask_q   <= mask_d;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_c[b]),
      .k     (k_c[b]),
      .q     (bank_q[b])
    );
  end

  assign bus.gnt       = gnt_c;
  assign bus.done      = (state_q == S_ACK);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.q         = bank_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-timeline reference model.
module tb_jk_bank_scheduler;
  import jk_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  jk_bank_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  jk_bank_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction accepted at edge s shows gnt after s, done and the new q
  // after s+1, and the arbiter may accept again at edge s+3.
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  logic             m_done;
  logic             m_busy;
  logic [1:0]       m_op;
  logic [WIDTH-1:0] m_mask;
  int               m_last;
  int               m_w;
  int               edge_n  = 0;
  int               start_e = -100;
  int               free_e  = 0;

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] q,
                                                input logic [1:0] o,
                                                input logic [WIDTH-1:0] m);
    case (o)
      2'b01:   return q & ~m;
      2'b10:   return q | m;
      2'b11:   return q ^ m;
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    m_q     = '0;
    m_last  = NREQ - 1;
    start_e = -100;
    free_e  = edge_n + 1;
    m_gnt   = '0;
    m_done  = 1'b0;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge();
    int i;
    edge_n++;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (edge_n == start_e + 1) begin
        m_q    = apply_op(m_q, m_op, m_mask);
        m_last = m_w;
      end
      if (edge_n >= free_e && bus.req != '0) begin
        for (int n = 1; n <= NREQ; n++) begin
          i = (m_last + n) % NREQ;
          if (bus.req[i] && start_e != edge_n) begin
            m_w     = i;
            m_op    = bus.op[2*i +: 2];
            m_mask  = bus.mask[WIDTH*i +: WIDTH];
            start_e = edge_n;
            free_e  = edge_n + 3;
          end
        end
      end
      m_gnt  = (edge_n == start_e) ? NREQ'(1 << m_w) : '0;
      m_done = (edge_n == start_e + 1);
      m_busy = (edge_n == start_e) || (edge_n == start_e + 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check("gnt",  32'(bus.gnt),  32'(m_gnt));
    check("done", 32'(bus.done), 32'(m_done));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("q",    32'(bus.q),    32'(m_q));
  endtask

  task automatic post(input int i, input logic [1:0] o, input logic [WIDTH-1:0] m);
    bus.req[i]              = 1'b1;
    bus.op[2*i +: 2]        = o;
    bus.mask[WIDTH*i +: WIDTH] = m;
  endtask

  logic [NREQ-1:0] first_gnt;

  // Post one op and wait for its grant; leaves the bench in the APPLY cycle.
  task automatic wait_gnt(input int i, input logic [1:0] o, input logic [WIDTH-1:0] m);
    int  t;
    logic granted;
    t = 0;
    granted = 1'b0;
    first_gnt = '0;
    post(i, o, m);
    while (!granted && t < 12) begin
      tick();
      t++;
      if (first_gnt == '0) first_gnt = bus.gnt;
      if (bus.gnt[i]) granted = 1'b1;
    end
    check("grant_seen", 32'(granted), 32'(1));
    bus.req[i] = 1'b0;
  endtask

  task automatic do_txn(input int i, input logic [1:0] o, input logic [WIDTH-1:0] m);
    wait_gnt(i, o, m);
    tick();
    check("done_pulse", 32'(bus.done), 32'(1));
    tick();
  endtask

  task automatic assert_reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_q",     32'(bus.q),         32'(0));
    check("rst_gnt",   32'(bus.gnt),       32'(0));
    check("rst_done",  32'(bus.done),      32'(0));
    check("rst_busy",  32'(bus.busy),      32'(0));
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    model_reset();
  endtask

  task automatic reset_pulse();
    assert_reset_now();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [NREQ-1:0] exp_q[$];
  int              gnt_cyc[$];

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int last_c;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op   = '0;
    bus.mask = '0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-sequence: bank already updated in ACK, cleared without a clock edge.
    wait_gnt(0, 2'b10, 8'h3C);
    tick();
    check("pre_rst_q", 32'(bus.q), 32'h3C);
    reset_pulse();
    tick();

    // SET, TOGGLE, HOLD on requester 0.
    wait_gnt(0, 2'b10, 8'h0F);
    check("set_gnt", 32'(first_gnt), 32'b0001);
    tick();
    check("set_q", 32'(bus.q), 32'h0F);
    tick();
    do_txn(0, 2'b11, 8'hFF);
    check("toggle_q", 32'(bus.q), 32'hF0);
    do_txn(0, 2'b00, 8'hFF);
    check("hold_q", 32'(bus.q), 32'hF0);

    // CLEAR with empty mask on 0xAA, from requester 1.
    do_txn(1, 2'b01, 8'hFF);
    do_txn(1, 2'b10, 8'hAA);
    check("aa_q", 32'(bus.q), 32'hAA);
    do_txn(1, 2'b01, 8'h00);
    check("clr_mask0_q", 32'(bus.q), 32'hAA);

    // Reset in APPLY discards the transaction and restarts arbitration.
    do_txn(3, 2'b11, 8'hFF);
    check("q55", 32'(bus.q), 32'h55);
    wait_gnt(0, 2'b10, 8'hFF);
    assert_reset_now();
    tick();
    tick();
    tick();
    check("apply_discard_q", 32'(bus.q), 32'h00);
    rst_n = 1'b1;
    do_txn(2, 2'b10, 8'h81);
    check("rr_after_reset", 32'(first_gnt), 32'b0100);
    check("q81", 32'(bus.q), 32'h81);

    // Round robin with every requester held high.
    reset_pulse();
    for (int i = 0; i < NREQ; i++) post(i, 2'b11, WIDTH'(1 << i));
    for (int n = 0; n < 5; n++) exp_q.push_back(NREQ'(1 << (n % NREQ)));
    for (int t = 0; t < 20 && gnt_cyc.size() < 5; t++) begin
      tick();
      if (bus.gnt != '0) begin
        check("rr_order", 32'(bus.gnt), 32'(exp_q.pop_front()));
        gnt_cyc.push_back(cyc);
      end
    end
    check("rr_count", 32'(gnt_cyc.size()), 32'(5));
    last_c = -1;
    foreach (gnt_cyc[n]) begin
      if (last_c >= 0) check("rr_spacing", 32'(gnt_cyc[n] - last_c), 32'(3));
      last_c = gnt_cyc[n];
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    // Random traffic: one-shot or repeating requesters with changing ops/masks.
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && bus.gnt[i]) begin
          if ($urandom_range(0, 3) != 0) bus.req[i] = 1'b0;
          bus.op[2*i +: 2]           = 2'($urandom_range(0, 3));
          bus.mask[WIDTH*i +: WIDTH] = WIDTH'($urandom);
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          post(i, 2'($urandom_range(0, 3)), WIDTH'($urandom));
        end
      end
      if (t == 300) reset_pulse();
      tick();
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
